// File: rtl/reflet_byte_mem_sequencer.sv
// reflet_byte_mem_sequencer: splits CPU loads/stores into little-endian byte accesses on a 1-cycle-latency byte memory.
// Define MEM_ALIGN_TRAP_EN to enable the misaligned-access trap.
module reflet_byte_mem_sequencer #(
   parameter int WORDSIZE   = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORDSIZE-1:0]   req_wdata,
   input  logic                  trap_en,
   output logic                  resp_valid,
   output logic [WORDSIZE-1:0]   resp_rdata,
   output logic                  misaligned,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata
);
   localparam int NB = WORDSIZE / 8;
   localparam int LG = $clog2(NB);
   localparam int CW = (LG > 0) ? LG : 1;
`ifdef MEM_ALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, TRAP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt, last_q, last_req, cap_idx;
   logic [1:0] lg_req;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORDSIZE-1:0] wdata_q, rbuf, asm;
   logic write_q, cap_v, misal_req, trap_go, accept, issuing;
   assign lg_req    = (req_size > 2'(LG)) ? 2'(LG) : req_size;
   assign last_req  = CW'((1 << lg_req) - 1);
   assign misal_req = |(req_addr[CW-1:0] & last_req);
   assign trap_go   = TRAP_ON & trap_en & misal_req;
   assign accept    = req_valid & (state_q == IDLE);
   assign issuing   = state_q == ISSUE;
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == DONE;
   assign misaligned = TRAP_ON & (state_q == TRAP);
   assign mem_rd     = issuing & ~write_q;
   assign mem_wr     = issuing & write_q;
   assign mem_addr   = issuing ? addr_q + ADDR_WIDTH'(cnt) : '0;
   assign mem_wdata  = mem_wr ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !req_valid ? IDLE : trap_go ? TRAP : ISSUE;
         ISSUE:   state_d = (cnt != last_q) ? ISSUE : write_q ? DONE : DRAIN;
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   // The byte returned this cycle belongs to the read issued last cycle.
   always_comb begin
      asm = rbuf;
      asm[{cap_idx, 3'b000} +: 8] = mem_rdata;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt        <= '0;
         last_q     <= '0;
         cap_idx    <= '0;
         cap_v      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         rbuf       <= '0;
         resp_rdata <= '0;
      end else begin
         state_q <= state_d;
         cap_v   <= mem_rd;
         cap_idx <= cnt;
         if (cap_v) rbuf <= asm;
         if (issuing) cnt <= cnt + 1'b1;
         if (state_q == DRAIN) resp_rdata <= asm;
         if (accept) begin
            addr_q  <= req_addr;
            last_q  <= last_req;
            wdata_q <= req_wdata;
            write_q <= req_write;
            cnt     <= '0;
            rbuf    <= '0;
         end
      end
   end
endmodule

// File: tb/tb_reflet_byte_mem_sequencer.sv
// tb_reflet_byte_mem_sequencer: vector table plus strobe scoreboard against a byte-memory model, WORDSIZE=32.
module tb_reflet_byte_mem_sequencer;
   localparam int WS = 32;
   localparam int AW = 16;
`ifdef MEM_ALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, trap_en = 1'b0;
   logic [1:0] req_size = '0;
   logic [AW-1:0] req_addr = '0;
   logic [WS-1:0] req_wdata = '0;
   logic req_ready, resp_valid, misaligned, mem_rd, mem_wr;
   logic [WS-1:0] resp_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic [7:0] mem [0:65535];

   reflet_byte_mem_sequencer #(.WORDSIZE(WS), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .trap_en(trap_en), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misaligned(misaligned),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic wr; logic [1:0] size; logic [15:0] addr; logic [31:0] wdata; logic trap; logic [31:0] exp;
   } vec_t;
   typedef struct { logic wr; logic [15:0] addr; logic [7:0] data; int cyc; } stb_t;
   vec_t v[11];
   stb_t q[$];
   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run(input int i);
      int n, t_resp, t_mis, t_rdy;
      logic mis;
      stb_t s;
      t_resp = 0; t_mis = 0; t_rdy = 0;
      n = 1 << ((v[i].size > 2) ? 2 : int'(v[i].size));
      mis = TRAP && v[i].trap && (int'(v[i].addr) % n != 0);
      if (!mis)
         for (int k = 0; k < n; k++)
            q.push_back('{v[i].wr, v[i].addr + 16'(k), v[i].wr ? v[i].wdata[8*k +: 8] : 8'h00, k + 1});
      @(negedge clk);
      chk($sformatf("v%0d ready_before", i), 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = v[i].wr; req_size = v[i].size;
      req_addr = v[i].addr; req_wdata = v[i].wdata; trap_en = v[i].trap;
      for (int c = 1; c <= 12 && t_rdy == 0; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (mem_rd | mem_wr) begin
            if (q.size() == 0) chk($sformatf("v%0d extra_strobe cyc%0d", i, c), 64'd1, 64'd0);
            else begin
               s = q.pop_front();
               chk($sformatf("v%0d strobe{wr,rd,addr,cyc}", i), {mem_wr, mem_rd, mem_addr, 8'(c)},
                   {s.wr, !s.wr, s.addr, 8'(s.cyc)});
               if (s.wr) chk($sformatf("v%0d wdata", i), 64'(mem_wdata), 64'(s.data));
            end
         end
         if (resp_valid && t_resp == 0) t_resp = c;
         if (misaligned && t_mis == 0) t_mis = c;
         if (req_ready) t_rdy = c;
      end
      chk($sformatf("v%0d resp_cycle", i), 64'(t_resp), 64'(mis ? 0 : (v[i].wr ? n + 1 : n + 2)));
      chk($sformatf("v%0d misaligned_cycle", i), 64'(t_mis), 64'(mis ? 1 : 0));
      chk($sformatf("v%0d ready_cycle", i), 64'(t_rdy), 64'(mis ? 2 : (v[i].wr ? n + 2 : n + 3)));
      chk($sformatf("v%0d rdata", i), 64'(resp_rdata), 64'(v[i].exp));
      chk($sformatf("v%0d missing_strobes", i), 64'(q.size()), 64'd0);
      q.delete();
   endtask

   initial begin
      logic [7:0] init [0:21];
      logic bad;
      init = '{8'h0F, 8'h18, 8'h3D, 8'h02, 8'h10, 8'h04, 8'h14, 8'h31, 8'h18, 8'h32, 8'hA1,
               8'h72, 8'h3D, 8'h00, 8'h00, 8'h11, 8'hF0, 8'h00, 8'h11, 8'hF0, 8'h00, 8'h0E};
      for (int a = 0; a < 65536; a++) mem[a] = (a < 22) ? init[a] : 8'h00;
      v[0]  = '{1'b0, 2'd1, 16'h0004, 32'h0, 1'b0, 32'h0000_0410};
      v[1]  = '{1'b0, 2'd1, 16'h0001, 32'h0, 1'b1, TRAP ? 32'h0000_0410 : 32'h0000_3D18};
      v[2]  = '{1'b0, 2'd1, 16'h0001, 32'h0, 1'b0, 32'h0000_3D18};
      v[3]  = '{1'b1, 2'd2, 16'h0008, 32'hA1B2_C3D4, 1'b0, 32'h0000_3D18};
      v[4]  = '{1'b0, 2'd2, 16'h0008, 32'h0, 1'b0, 32'hA1B2_C3D4};
      v[5]  = '{1'b0, 2'd1, 16'hFFFF, 32'h0, 1'b0, 32'h0000_0F00};
      v[6]  = '{1'b0, 2'd0, 16'h0003, 32'h0, 1'b1, 32'h0000_0002};
      v[7]  = '{1'b0, 2'd3, 16'h0010, 32'h0, 1'b0, 32'hF011_00F0};
      v[8]  = '{1'b1, 2'd0, 16'h0015, 32'h0000_005A, 1'b1, 32'hF011_00F0};
      v[9]  = '{1'b0, 2'd1, 16'h0014, 32'h0, 1'b0, 32'h0000_5A00};
      v[10] = '{1'b0, 2'd2, 16'h0002, 32'h0, 1'b1, TRAP ? 32'h0000_5A00 : 32'h0410_023D};
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("reset ready", 64'(req_ready), 64'd1);
      chk("reset outputs", {resp_valid, misaligned, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);
      chk("reset rdata", 64'(resp_rdata), 64'd0);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 16'h0000; trap_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort cyc1 rd", {mem_rd, mem_addr}, {1'b1, 16'h0000});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort strobes", {mem_rd, mem_wr, resp_valid, misaligned}, 64'd0);
      chk("abort rdata", 64'(resp_rdata), 64'd0);
      chk("abort ready", 64'(req_ready), 64'd1);
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid | mem_rd | mem_wr) bad = 1'b1;
      end
      chk("abort quiet", 64'(bad), 64'd0);
      for (int i = 0; i < 11; i++) run(i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
